// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-port parity RAM.
package mem_pkg;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   function automatic int num_bytes(input int width, input int byte_width);
      return width / byte_width;
   endfunction

endpackage

// File: rtl/dp_ram_ecc_lite_if.sv
// Write/read request bus and status of the dual-port parity RAM.
interface dp_ram_ecc_lite_if
   import mem_pkg::*;
#(
   parameter int MEM_WIDTH  = 16,
   parameter int ADDR_SIZE  = 10,
   parameter int BYTE_WIDTH = 8
);
   localparam int NUM_BYTES = num_bytes(MEM_WIDTH, BYTE_WIDTH);

   logic                 wr_en;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [MEM_WIDTH-1:0] wr_data;
   logic [NUM_BYTES-1:0] wr_be;
   logic [NUM_BYTES-1:0] wr_par_flip;
   logic                 rd_en;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic [MEM_WIDTH-1:0] rd_data;
   logic                 rd_valid;
   logic                 parity_err;
   logic                 err_sticky;
   logic                 err_clr;
   logic                 init_busy;

   modport master (
      output wr_en, wr_addr, wr_data, wr_be, wr_par_flip,
      output rd_en, rd_addr, err_clr,
      input  rd_data, rd_valid, parity_err, err_sticky, init_busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_be, wr_par_flip,
      input  rd_en, rd_addr, err_clr,
      output rd_data, rd_valid, parity_err, err_sticky, init_busy
   );

endinterface

// File: rtl/byte_parity_gen.sv
// Even parity of each byte lane of a data word.
module byte_parity_gen #(
   parameter int WIDTH      = 16,
   parameter int BYTE_WIDTH = 8,
   parameter int NUM_BYTES  = 2
) (
   input  logic [WIDTH-1:0]     data,
   output logic [NUM_BYTES-1:0] par
);

   always_comb begin
      par = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         par[i] = ^data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

endmodule

// File: rtl/dp_ram_ecc_lite.sv
// Simple dual-port RAM with byte enables, per-lane parity,
// optional output register and zero-fill after reset.
module dp_ram_ecc_lite
   import mem_pkg::*;
#(
   parameter int MEM_WIDTH      = 16,
   parameter int MEM_DEPTH      = 1024,
   parameter int ADDR_SIZE      = 10,
   parameter int BYTE_WIDTH     = 8,
   parameter int DOUT_PIPELINE  = 1,
   parameter int PARITY_ENABLE  = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input logic             clk,
   input logic             rst,
   dp_ram_ecc_lite_if.slave bus
);

   localparam int NB = num_bytes(MEM_WIDTH, BYTE_WIDTH);
   localparam int AW = ADDR_SIZE + 1;
   localparam logic [ADDR_SIZE:0] DEPTH_A = AW'(MEM_DEPTH);
   localparam logic [ADDR_SIZE:0] LAST_A  = DEPTH_A - AW'(1);

   state_t               state;
   logic [ADDR_SIZE:0]   init_cnt;
   logic                 init_busy_q;
   logic                 run;
   logic                 wr_in;
   logic                 rd_in;
   logic                 wr_ok;
   logic                 rd_fire;
   logic                 rd_mem;

   logic                 w_en;
   logic [ADDR_SIZE-1:0] w_addr;
   logic [NB-1:0]        w_lane;
   logic [MEM_WIDTH-1:0] w_data;
   logic [NB-1:0]        w_par;
   logic [NB-1:0]        wr_par_calc;

   logic [MEM_WIDTH-1:0] q_data;
   logic [NB-1:0]        q_par;
   logic [NB-1:0]        rd_par_calc;
   logic                 s1_valid;
   logic                 s1_oor;
   logic [MEM_WIDTH-1:0] chk_data;
   logic                 chk_err;

   logic                 p_valid;
   logic [MEM_WIDTH-1:0] p_data;
   logic                 p_err;

   logic [MEM_WIDTH-1:0] rd_data_q;
   logic                 rd_valid_q;
   logic                 parity_err_q;
   logic                 err_sticky_q;

   assign run     = (state == ST_RUN);
   assign wr_in   = ({1'b0, bus.wr_addr} < DEPTH_A);
   assign rd_in   = ({1'b0, bus.rd_addr} < DEPTH_A);
   assign wr_ok   = run & bus.wr_en & wr_in;
   assign rd_fire = run & bus.rd_en;
   assign rd_mem  = rd_fire & rd_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
         init_cnt    <= '0;
         init_busy_q <= (CLEAR_ON_RESET != 0);
      end else begin
         unique case (state)
            ST_INIT: begin
               if (init_cnt == LAST_A) begin
                  state       <= ST_RUN;
                  init_busy_q <= 1'b0;
               end else begin
                  init_cnt <= init_cnt + AW'(1);
               end
            end
            ST_RUN: ;
            default: state <= ST_RUN;
         endcase
      end
   end

   byte_parity_gen #(
      .WIDTH     (MEM_WIDTH),
      .BYTE_WIDTH(BYTE_WIDTH),
      .NUM_BYTES (NB)
   ) u_wr_par (
      .data(bus.wr_data),
      .par (wr_par_calc)
   );

   // The sweep owns the write port while it runs.
   always_comb begin
      w_en   = 1'b0;
      w_addr = bus.wr_addr;
      w_lane = '0;
      w_data = bus.wr_data;
      w_par  = '0;
      unique case (1'b1)
         !run: begin
            w_en   = 1'b1;
            w_addr = init_cnt[ADDR_SIZE-1:0];
            w_lane = '1;
            w_data = '0;
            w_par  = '0;
         end
         wr_ok: begin
            w_en   = 1'b1;
            w_lane = bus.wr_be;
            w_par  = wr_par_calc ^ bus.wr_par_flip;
         end
         default: ;
      endcase
   end

   generate
      if (PARITY_ENABLE != 0) begin : g_par
         logic [MEM_WIDTH+NB-1:0] mem [MEM_DEPTH];
         logic [MEM_WIDTH+NB-1:0] raw_q;

         always_ff @(posedge clk) begin
            if (w_en) begin
               for (int i = 0; i < NB; i++) begin
                  if (w_lane[i]) begin
                     mem[w_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        w_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                     mem[w_addr][MEM_WIDTH+i] <= w_par[i];
                  end
               end
            end
            if (rd_mem) raw_q <= mem[bus.rd_addr];
         end

         assign q_data = raw_q[MEM_WIDTH-1:0];
         assign q_par  = raw_q[MEM_WIDTH +: NB];
      end else begin : g_nopar
         logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
         logic [MEM_WIDTH-1:0] raw_q;

         always_ff @(posedge clk) begin
            if (w_en) begin
               for (int i = 0; i < NB; i++) begin
                  if (w_lane[i]) begin
                     mem[w_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        w_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                  end
               end
            end
            if (rd_mem) raw_q <= mem[bus.rd_addr];
         end

         assign q_data = raw_q;
         assign q_par  = '0;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_oor   <= 1'b0;
      end else begin
         s1_valid <= rd_fire;
         s1_oor   <= rd_fire & ~rd_in;
      end
   end

   byte_parity_gen #(
      .WIDTH     (MEM_WIDTH),
      .BYTE_WIDTH(BYTE_WIDTH),
      .NUM_BYTES (NB)
   ) u_rd_par (
      .data(q_data),
      .par (rd_par_calc)
   );

   // Out-of-range reads bypass the array and never flag an error.
   assign chk_data = s1_oor ? '0 : q_data;
   assign chk_err  = (PARITY_ENABLE != 0) && !s1_oor &&
                     (|(q_par ^ rd_par_calc));

   generate
      if (DOUT_PIPELINE != 0) begin : g_pipe
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               p_valid <= 1'b0;
               p_data  <= '0;
               p_err   <= 1'b0;
            end else begin
               p_valid <= s1_valid;
               p_err   <= s1_valid & chk_err;
               if (s1_valid) p_data <= chk_data;
            end
         end
      end else begin : g_nopipe
         assign p_valid = s1_valid;
         assign p_data  = chk_data;
         assign p_err   = chk_err;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         rd_valid_q   <= p_valid;
         parity_err_q <= p_valid & p_err;
         if (p_valid) rd_data_q <= p_data;
         if (p_valid & p_err)  err_sticky_q <= 1'b1;
         else if (bus.err_clr) err_sticky_q <= 1'b0;
      end
   end

   assign bus.rd_data    = rd_data_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.parity_err = parity_err_q;
   assign bus.err_sticky = err_sticky_q;
   assign bus.init_busy  = init_busy_q;

endmodule
